// File: rtl/pq_batch_sorter.sv
// Batch sorter: streams a batch of kv_t items into an attached HWPQ,
// then drains it back out in ascending key order.
package pq_pkg;
    localparam int KEY_W       = 8;
    localparam int VAL_W       = 8;
    localparam int PQ_CAPACITY = 63;
    localparam logic [KEY_W-1:0] KEYINF = '1;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [VAL_W-1:0] value;
    } kv_t;
endpackage

module pq_batch_sorter
    import pq_pkg::*;
#(
    parameter int CAPACITY = PQ_CAPACITY,
    parameter int BATCH_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  kv_t                in_kv,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output kv_t                out_kv,
    output logic               out_last,
    output logic               pq_enq,
    output logic               pq_deq,
    output kv_t                pq_kvi,
    input  kv_t                pq_kvo,
    input  logic               pq_busy,
    input  logic               pq_full,
    input  logic               pq_empty,
    output logic               err_inf,
    output logic               overflow,
    output logic [BATCH_W-1:0] batches_done
);

    localparam int CNT_W = $clog2(CAPACITY + 1);
    localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    typedef enum logic {
        FILL,
        DRAIN
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [BATCH_W-1:0] batches_q, batches_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            count_q   <= '0;
            batches_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            batches_q <= batches_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        batches_d = batches_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_kv    = '0;
        out_last  = 1'b0;
        pq_enq    = 1'b0;
        pq_deq    = 1'b0;
        pq_kvi    = '0;
        err_inf   = 1'b0;
        overflow  = 1'b0;

        unique case (state_q)
            FILL: begin
                in_ready = !pq_busy && !pq_full && (count_q < CAP_C);
                if (in_valid && in_ready) begin
                    // KEYINF is the HWPQ's empty-slot marker, so it is dropped
                    if (in_kv.key == KEYINF) begin
                        err_inf = 1'b1;
                    end else begin
                        pq_enq  = 1'b1;
                        pq_kvi  = in_kv;
                        count_d = count_q + ONE_C;
                    end
                    if (in_last) begin
                        if (count_d != '0) state_d = DRAIN;
                    end else if (count_d == CAP_C) begin
                        state_d  = DRAIN;
                        overflow = 1'b1;
                    end
                end
            end
            DRAIN: begin
                out_valid = !pq_busy && !pq_empty && (count_q != '0);
                out_kv    = out_valid ? pq_kvo : '0;
                out_last  = out_valid && (count_q == ONE_C);
                pq_deq    = out_valid && out_ready;
                if (pq_deq) begin
                    count_d = count_q - ONE_C;
                    if (count_q == ONE_C) begin
                        state_d   = FILL;
                        batches_d = batches_q + 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    assign batches_done = batches_q;

endmodule
